data_memory_p: RTL and testbench

Parametrised single-port synchronous data memory, the next generation of the processor's 8-bit data memory. Keeps the `w` polarity (0 = write, 1 = read) and the identity power-up pattern, and adds a request/ready handshake, a read-valid strobe, a post-reset initialisation sequencer, and out-of-range address detection. Sits between the datapath's load/store stage and the register file write-back.

---
 rtl/data_memory_p.sv | 107 ++++++++++
 tb/tb_data_memory_p.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_p.sv
// data_memory_p: single-port synchronous data memory with req/ready handshake,
// read-valid strobe and out-of-range detection. Define DMEM_INIT_EN to add the identity-pattern init sequencer.
module data_memory_p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              w,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataIn,
  output logic              ready,
  output logic [DATA_W-1:0] dataOut,
  output logic              rvalid,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Without the init sequencer ST_INIT lasts exactly one edge after reset.
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_in_range;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_idx;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_dout_nxt;
  logic              w_rvalid_nxt;
  logic              w_err_nxt;

  assign w_in_range = {1'b0, address} < (ADDR_W+1)'(DEPTH);
  assign ready      = (r_state == ST_RUN);

`ifdef DMEM_INIT_EN
  logic [IDX_W-1:0] r_cnt;
  logic             w_cnt_last;

  assign w_cnt_last = (r_cnt == IDX_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + IDX_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      dataOut <= '0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      dataOut <= w_dout_nxt;
      rvalid  <= w_rvalid_nxt;
      err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mem_we     = 1'b0;
    w_mem_idx    = address[IDX_W-1:0];
    w_mem_wdata  = dataIn;
    w_dout_nxt   = dataOut;
    w_rvalid_nxt = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      ST_INIT: begin
`ifdef DMEM_INIT_EN
        w_mem_we    = 1'b1;
        w_mem_idx   = r_cnt;
        w_mem_wdata = DATA_W'(r_cnt);
        if (w_cnt_last) w_state_nxt = ST_RUN;
`else
        w_state_nxt = ST_RUN;
`endif
      end
      ST_RUN: begin
        if (req) begin
          if (w) begin
            w_rvalid_nxt = 1'b1;
            w_dout_nxt   = w_in_range ? r_mem[w_mem_idx] : '0;
          end else begin
            w_mem_we = w_in_range;
          end
          w_err_nxt = !w_in_range;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
  end

endmodule

// File: tb/tb_data_memory_p.sv
// Self-checking bench for data_memory_p against an array-based reference model.
`timescale 1ns/1ps
module tb_data_memory_p;

`ifdef DMEM_INIT_EN
  localparam int DW       = 8;
  localparam int DEPTH    = 32;
  localparam int INIT_LAT = DEPTH;
`else
  localparam int DW       = 16;
  localparam int DEPTH    = 64;
  localparam int INIT_LAT = 1;
`endif
  localparam int AW = 8;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          req     = 1'b0;
  logic          w       = 1'b1;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] dataIn  = '0;
  logic          ready;
  logic          rvalid;
  logic          err;
  logic [DW-1:0] dataOut;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [DW-1:0] model [DEPTH];
  bit            known [DEPTH];
  logic [DW-1:0] exp_dout;

  always #5 clk = ~clk;

  data_memory_p #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .w(w), .address(address),
    .dataIn(dataIn), .ready(ready), .dataOut(dataOut), .rvalid(rvalid), .err(err)
  );

  task automatic model_after_reset();
    for (int i = 0; i < DEPTH; i++) begin
`ifdef DMEM_INIT_EN
      model[i] = DW'(i);
      known[i] = 1'b1;
`else
      // Contents survive reset when there is no init sequencer.
      if (!known[i]) model[i] = 'x;
`endif
    end
    exp_dout = '0;
  endtask

  task automatic check_quiet_outputs(input string tag);
    n_checks++;
    if (dataOut !== '0 || rvalid !== 1'b0 || err !== 1'b0 || ready !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: dataOut=%h rvalid=%b err=%b ready=%b, required 0 0 0 0",
               tag, dataOut, rvalid, err, ready);
    end
  endtask

  // One accepted operation; wr_n follows the w polarity (0 = write, 1 = read).
  task automatic do_op(input logic wr_n, input int addr, input logic [DW-1:0] d, input string tag);
    bit in_range;
    @(negedge clk);
    req = 1'b1; w = wr_n; address = AW'(addr); dataIn = d;
    in_range = (addr < DEPTH);
    if (in_range) begin
      if (!wr_n) begin
        model[addr] = d;
        known[addr] = 1'b1;
      end else begin
        exp_dout = model[addr];
      end
    end else if (wr_n) begin
      exp_dout = '0;
    end
    @(posedge clk);
    #1;
    req = 1'b0;
    n_checks++;
    if (dataOut !== exp_dout) begin
      n_errors++;
      $display("FAIL %s_data: addr=%0d dataOut=%h required %h", tag, addr, dataOut, exp_dout);
    end
    n_checks++;
    if (rvalid !== wr_n) begin
      n_errors++;
      $display("FAIL %s_rvalid: addr=%0d rvalid=%b required %b", tag, addr, rvalid, wr_n);
    end
    n_checks++;
    if (err !== !in_range) begin
      n_errors++;
      $display("FAIL %s_err: addr=%0d err=%b required %b", tag, addr, err, !in_range);
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (dataOut !== exp_dout || rvalid !== 1'b0 || err !== 1'b0 || ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s: dataOut=%h rvalid=%b err=%b ready=%b, required %h 0 0 1",
               tag, dataOut, rvalid, err, ready, exp_dout);
    end
  endtask

  // Releases reset and counts edges until ready rises; optional write request held meanwhile.
  task automatic release_count(input int exp_lat, input bit hold_req, input string tag);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    if (hold_req) begin
      req = 1'b1; w = 1'b0; address = AW'(3); dataIn = DW'('h77);
    end
    while (!done && n < exp_lat + 8) begin
      @(posedge clk);
      #1;
      n++;
      n_checks++;
      if (rvalid !== 1'b0 || err !== 1'b0) begin
        n_errors++;
        $display("FAIL %s_quiet: edge %0d rvalid=%b err=%b required 0 0", tag, n, rvalid, err);
      end
      if (ready === 1'b1) done = 1'b1;
    end
    req = 1'b0;
    n_checks++;
    if (!done || n != exp_lat) begin
      n_errors++;
      $display("FAIL %s: ready rose=%0d after %0d edges, required after %0d", tag, done, n, exp_lat);
    end
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_quiet_outputs("reset_held");
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    model_after_reset();
  endtask

  task automatic test_init();
    release_count(INIT_LAT, 1'b1, "init_latency");
`ifdef DMEM_INIT_EN
    do_op(1'b1, 0, '0, "init_rd0");
    do_op(1'b1, 5, '0, "init_rd5");
    do_op(1'b1, DEPTH - 1, '0, "init_rdlast");
    do_op(1'b1, 3, '0, "dropped_req");
`else
    for (int i = 0; i < DEPTH; i++) do_op(1'b0, i, DW'($urandom), "fill");
`endif
  endtask

  task automatic test_back_to_back();
    for (int a = 1; a <= 4; a++) do_op(1'b1, a, '0, "b2b_read");
    idle_cycle("b2b_after");
  endtask

  task automatic test_write_read();
    do_op(1'b0, 7, DW'('hA5), "wr7");
    do_op(1'b1, 7, '0, "wr_then_rd7");
    do_op(1'b1, 7, '0, "rd_before_wr7");
    do_op(1'b0, 7, DW'('h3C), "wr7_after_rd");
    do_op(1'b1, 7, '0, "rd7_new");
    do_op(1'b0, DEPTH - 1, DW'('hBEEF), "wr_last");
    do_op(1'b1, DEPTH - 1, '0, "rd_last");
    idle_cycle("hold_after_read");
  endtask

  task automatic test_out_of_range();
    do_op(1'b0, DEPTH + 8, DW'('hFF), "oor_write");
    do_op(1'b1, 8, '0, "alias_untouched");
    do_op(1'b1, 200, '0, "oor_read200");
    do_op(1'b1, 1, '0, "rd_after_oor");
    do_op(1'b0, DEPTH, DW'('h5A), "oor_write_edge");
    do_op(1'b1, DEPTH, '0, "oor_read_edge");
    do_op(1'b1, 255, '0, "oor_read_max");
    do_op(1'b1, 0, '0, "rd0_after_oor");
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      int  addr;
      int  r;
      bit  wr_n;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        idle_cycle("rand_idle");
      end else begin
        if (r < 9) addr = $urandom_range(0, DEPTH - 1);
        else       addr = $urandom_range(DEPTH, 255);
        wr_n = $urandom_range(0, 1);
        if (addr < DEPTH && !known[addr]) wr_n = 1'b0;
        do_op(wr_n, addr, DW'($urandom), "rand");
      end
    end
  endtask

  task automatic test_reset_mid();
    do_op(1'b1, 5, '0, "pre_reset_rd");
    @(negedge clk);
    req = 1'b1; w = 1'b1; address = AW'(9);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet_outputs("reset_mid_op");
    @(posedge clk);
    #1;
    check_quiet_outputs("inflight_read_dropped");
    req = 1'b0;
    model_after_reset();
`ifdef DMEM_INIT_EN
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_quiet_outputs("reset_mid_init");
`endif
    release_count(INIT_LAT, 1'b0, "reinit_latency");
    do_op(1'b1, 7, '0, "post_reset_rd7");
    do_op(1'b1, DEPTH - 1, '0, "post_reset_rdlast");
    do_op(1'b1, 5, '0, "post_reset_rd5");
  endtask

  initial begin
    test_reset();
    test_init();
    test_back_to_back();
    test_write_read();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
